// File: rtl/mult_result_checker_if.sv
// Operand/product triple input and comparison-result output of the
// multiplier result checker, grouped as one bundle.
interface mult_result_checker_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   p_dut;
  logic                 res_valid;
  logic                 res_match;
  logic [2*WIDTH-1:0]   res_expected;

  // Harness side: presents triples, observes results.
  modport master (
    output in_valid, a, b, p_dut,
    input  in_ready, res_valid, res_match, res_expected
  );

  // Checker side.
  modport slave (
    input  in_valid, a, b, p_dut,
    output in_ready, res_valid, res_match, res_expected
  );
endinterface

// File: rtl/mult_result_checker.sv
// Golden-model checker for a candidate multiplier: recomputes A*B with a
// shift-add engine (one step per cycle), compares against the DUT product
// and accumulates saturating error statistics.
module mult_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  mult_result_checker_if.slave  bus,
  output logic [CNT_W-1:0]      total_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [ACC_W-1:0]      abs_err_sum,
  output logic [2*WIDTH-1:0]    max_abs_err
);

  localparam int PW     = 2 * WIDTH;
  localparam int STEP_W = $clog2(WIDTH + 1);
  // Sum is formed one bit wider than the wider addend so overflow is visible.
  localparam int SUM_W  = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [PW-1:0]       a_shift_r;
  logic [WIDTH-1:0]    b_shift_r;
  logic [PW-1:0]       acc_r;
  logic [PW-1:0]       p_dut_r;
  logic [STEP_W-1:0]   step_r;
  logic [PW-1:0]       diff_s;
  logic [SUM_W-1:0]    sum_ext_s;
  logic [ACC_W-1:0]    sum_next_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: accept in IDLE, WIDTH shift-add steps, one compare cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (step_r == STEP_W'(1)) begin
          state_next_s = ST_CMP;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_CMP:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture and shift-add multiplication datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_shift_r <= {PW{1'b0}};
      b_shift_r <= {WIDTH{1'b0}};
      acc_r     <= {PW{1'b0}};
      p_dut_r   <= {PW{1'b0}};
      step_r    <= {STEP_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_shift_r <= {{WIDTH{1'b0}}, bus.a};
            b_shift_r <= bus.b;
            p_dut_r   <= bus.p_dut;
            acc_r     <= {PW{1'b0}};
            step_r    <= STEP_W'(WIDTH);
          end
        end
        ST_CALC: begin
          if (b_shift_r[0]) begin
            acc_r <= acc_r + a_shift_r;
          end
          a_shift_r <= a_shift_r << 1;
          b_shift_r <= b_shift_r >> 1;
          step_r    <= step_r - STEP_W'(1);
        end
        default: begin
          step_r <= step_r;
        end
      endcase
    end
  end

  // Absolute error and saturating error-sum candidate for the compare cycle.
  always_comb begin
    diff_s     = {PW{1'b0}};
    sum_ext_s  = {SUM_W{1'b0}};
    sum_next_s = {ACC_W{1'b0}};
    if (acc_r >= p_dut_r) begin
      diff_s = acc_r - p_dut_r;
    end else begin
      diff_s = p_dut_r - acc_r;
    end
    sum_ext_s = SUM_W'(abs_err_sum) + SUM_W'(diff_s);
    if (sum_ext_s > SUM_W'({ACC_W{1'b1}})) begin
      sum_next_s = {ACC_W{1'b1}};
    end else begin
      sum_next_s = ACC_W'(sum_ext_s);
    end
  end

  // Registered handshake, result and statistics outputs; clear beats update.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready     <= 1'b1;
      bus.res_valid    <= 1'b0;
      bus.res_match    <= 1'b0;
      bus.res_expected <= {PW{1'b0}};
      total_cnt        <= {CNT_W{1'b0}};
      err_cnt          <= {CNT_W{1'b0}};
      abs_err_sum      <= {ACC_W{1'b0}};
      max_abs_err      <= {PW{1'b0}};
    end else begin
      bus.in_ready  <= (state_next_s == ST_IDLE);
      bus.res_valid <= (state_r == ST_CMP);
      if (state_r == ST_CMP) begin
        bus.res_expected <= acc_r;
        bus.res_match    <= (diff_s == {PW{1'b0}});
      end
      if (clear) begin
        total_cnt   <= {CNT_W{1'b0}};
        err_cnt     <= {CNT_W{1'b0}};
        abs_err_sum <= {ACC_W{1'b0}};
        max_abs_err <= {PW{1'b0}};
      end else if (state_r == ST_CMP) begin
        if (total_cnt != {CNT_W{1'b1}}) begin
          total_cnt <= total_cnt + CNT_W'(1);
        end
        if ((diff_s != {PW{1'b0}}) && (err_cnt != {CNT_W{1'b1}})) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        abs_err_sum <= sum_next_s;
        if (diff_s > max_abs_err) begin
          max_abs_err <= diff_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_result_checker.sv
// Self-checking bench for mult_result_checker: directed and randomized
// triples compared against an arithmetic reference model.
module tb_mult_result_checker;
  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  mult_result_checker_if #(.WIDTH(WIDTH)) bus ();
  mult_result_checker_if #(.WIDTH(WIDTH)) bus_s ();

  logic [15:0]   total_cnt, err_cnt, max_abs_err;
  logic [31:0]   abs_err_sum;
  logic [3:0]    s_total, s_err;
  logic [31:0]   s_sum;
  logic [15:0]   s_max;

  mult_result_checker #(.WIDTH(WIDTH), .CNT_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus),
    .total_cnt(total_cnt), .err_cnt(err_cnt),
    .abs_err_sum(abs_err_sum), .max_abs_err(max_abs_err)
  );

  mult_result_checker #(.WIDTH(WIDTH), .CNT_W(4), .ACC_W(32)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus_s),
    .total_cnt(s_total), .err_cnt(s_err),
    .abs_err_sum(s_sum), .max_abs_err(s_max)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference statistics (16-bit counters, 32-bit sum, saturating).
  longint m_total, m_err, m_sum, m_max;

  function automatic void model_clear();
    m_total = 0; m_err = 0; m_sum = 0; m_max = 0;
  endfunction

  function automatic void model_txn(input longint av, input longint bv, input longint pv);
    longint e, d;
    e = av * bv;
    d = (e > pv) ? e - pv : pv - e;
    if (m_total < 65535) m_total = m_total + 1;
    if (d != 0 && m_err < 65535) m_err = m_err + 1;
    m_sum = m_sum + d;
    if (m_sum > 64'd4294967295) m_sum = 64'd4294967295;
    if (d > m_max) m_max = d;
  endfunction

  // One transaction; lat = edges after acceptance until res_valid seen.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] pv,
                      input int clr_k, output int lat, output bit ready_ok);
    lat = -1;
    ready_ok = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = av; bus.b = bv; bus.p_dut = pv;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 2 * WIDTH + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        lat = k;
        if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
        clear = 1'b0;
        break;
      end
      if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
      clear = (k == clr_k);
    end
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_match !== 1'b0 ||
        bus.res_expected !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b match=%b exp=%0d want 1 0 0 0",
               bus.in_ready, bus.res_valid, bus.res_match, bus.res_expected);
    end
    n_cmp++;
    if (total_cnt !== 16'd0 || err_cnt !== 16'd0 || abs_err_sum !== 32'd0 || max_abs_err !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d %0d %0d %0d want all 0", total_cnt, err_cnt, abs_err_sum, max_abs_err);
    end
  endtask

  task automatic test_basic();
    int lat; bit rok;
    send(8'd2, 8'd3, 16'd6, -1, lat, rok);
    model_txn(2, 3, 6);
    n_cmp++;
    if (lat !== WIDTH + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, WIDTH + 1); end
    n_cmp++;
    if (rok !== 1'b1) begin n_fail++; $display("FAIL basic_ready: in_ready not low while busy / high at result"); end
    n_cmp++;
    if (bus.res_expected !== 16'd6 || bus.res_match !== 1'b1) begin
      n_fail++; $display("FAIL basic_result: got exp=%0d match=%b want 6 1", bus.res_expected, bus.res_match);
    end
    n_cmp++;
    if (total_cnt !== 16'(m_total) || err_cnt !== 16'(m_err) || abs_err_sum !== 32'(m_sum)) begin
      n_fail++; $display("FAIL basic_stats: got %0d %0d %0d want %0d %0d %0d",
                         total_cnt, err_cnt, abs_err_sum, m_total, m_err, m_sum);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.res_expected !== 16'd6) begin
      n_fail++; $display("FAIL basic_pulse_hold: got vld=%b exp=%0d want 0 6", bus.res_valid, bus.res_expected);
    end
  endtask

  task automatic test_mismatch();
    int lat; bit rok;
    send(8'd3, 8'd3, 16'd7, -1, lat, rok);
    model_txn(3, 3, 7);
    n_cmp++;
    if (bus.res_match !== 1'b0 || bus.res_expected !== 16'd9) begin
      n_fail++; $display("FAIL mism_result: got match=%b exp=%0d want 0 9", bus.res_match, bus.res_expected);
    end
    n_cmp++;
    if (err_cnt !== 16'(m_err) || abs_err_sum !== 32'(m_sum) || max_abs_err !== 16'(m_max)) begin
      n_fail++; $display("FAIL mism_stats: got %0d %0d %0d want %0d %0d %0d",
                         err_cnt, abs_err_sum, max_abs_err, m_err, m_sum, m_max);
    end
    send(8'd255, 8'd255, 16'd65025, -1, lat, rok);
    model_txn(255, 255, 65025);
    n_cmp++;
    if (bus.res_expected !== 16'd65025 || bus.res_match !== 1'b1 || max_abs_err !== 16'(m_max)) begin
      n_fail++; $display("FAIL max_operands: got exp=%0d match=%b max=%0d want 65025 1 %0d",
                         bus.res_expected, bus.res_match, max_abs_err, m_max);
    end
  endtask

  task automatic test_random();
    int lat; bit rok;
    logic [7:0] av, bv;
    logic [15:0] pv;
    int e;
    for (int i = 0; i < 16; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      if (i == 0) av = 8'd0;
      e = int'(av) * int'(bv);
      pv = ($urandom_range(0, 1) == 1) ? 16'(e) : 16'($urandom_range(0, 65535));
      send(av, bv, pv, -1, lat, rok);
      model_txn(av, bv, pv);
      n_cmp++;
      if (bus.res_expected !== 16'(e) || bus.res_match !== (pv == 16'(e)) || lat !== WIDTH + 1) begin
        n_fail++; $display("FAIL rand_result[%0d]: got exp=%0d match=%b lat=%0d want %0d %b %0d",
                           i, bus.res_expected, bus.res_match, lat, e, (pv == 16'(e)), WIDTH + 1);
      end
    end
    n_cmp++;
    if (total_cnt !== 16'(m_total) || err_cnt !== 16'(m_err) ||
        abs_err_sum !== 32'(m_sum) || max_abs_err !== 16'(m_max)) begin
      n_fail++; $display("FAIL rand_stats: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         total_cnt, err_cnt, abs_err_sum, max_abs_err, m_total, m_err, m_sum, m_max);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n, pulses, last, gap_bad, bad_res;
    bit will_acc;
    int exp_q[$];
    acc_n = 0; pulses = 0; last = -1; gap_bad = 0; bad_res = 0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    n_cmp++;
    if (total_cnt !== 16'd0 || err_cnt !== 16'd0 || abs_err_sum !== 32'd0 || max_abs_err !== 16'd0) begin
      n_fail++; $display("FAIL idle_clear: got %0d %0d %0d %0d want all 0", total_cnt, err_cnt, abs_err_sum, max_abs_err);
    end
    bus.in_valid = 1'b1;
    bus.a = 8'($urandom_range(1, 3)); bus.b = 8'($urandom_range(1, 3));
    bus.p_dut = 16'(bus.a) * 16'(bus.b);
    for (int cyc = 0; cyc < 20 * (WIDTH + 2) + 40; cyc++) begin
      will_acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      if (will_acc) begin
        exp_q.push_back(int'(bus.a) * int'(bus.b));
        model_txn(bus.a, bus.b, bus.p_dut);
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        pulses++;
        if (last >= 0 && cyc - last != WIDTH + 2) gap_bad++;
        last = cyc;
        if (exp_q.size() == 0) bad_res++;
        else if (bus.res_expected !== 16'(exp_q.pop_front()) || bus.res_match !== 1'b1) bad_res++;
      end
      if (will_acc) begin
        acc_n++;
        if (acc_n == 20) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.a = 8'($urandom_range(1, 3)); bus.b = 8'($urandom_range(1, 3));
          bus.p_dut = 16'(bus.a) * 16'(bus.b);
        end
      end
    end
    n_cmp++;
    if (pulses !== 20 || gap_bad !== 0) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d pulses, %0d bad gaps want 20, 0", pulses, gap_bad);
    end
    n_cmp++;
    if (bad_res !== 0) begin n_fail++; $display("FAIL b2b_results: got %0d wrong results want 0", bad_res); end
    n_cmp++;
    if (total_cnt !== 16'd20 || err_cnt !== 16'd0 || total_cnt !== 16'(m_total)) begin
      n_fail++; $display("FAIL b2b_stats: got total=%0d err=%0d want 20 0", total_cnt, err_cnt);
    end
  endtask

  task automatic test_clear_cmp();
    int lat; bit rok;
    send(8'd5, 8'd7, 16'd30, WIDTH, lat, rok);
    model_clear();
    n_cmp++;
    if (lat !== WIDTH + 1 || bus.res_match !== 1'b0 || bus.res_expected !== 16'd35) begin
      n_fail++; $display("FAIL clear_cmp_result: got lat=%0d match=%b exp=%0d want %0d 0 35",
                         lat, bus.res_match, bus.res_expected, WIDTH + 1);
    end
    n_cmp++;
    if (total_cnt !== 16'd0 || err_cnt !== 16'd0 || abs_err_sum !== 32'd0 || max_abs_err !== 16'd0) begin
      n_fail++; $display("FAIL clear_cmp_stats: got %0d %0d %0d %0d want all 0",
                         total_cnt, err_cnt, abs_err_sum, max_abs_err);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; bit rok;
    send(8'd4, 8'd4, 16'd0, -1, lat, rok);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'd9; bus.b = 8'd9; bus.p_dut = 16'd81;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_expected !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got rdy=%b vld=%b exp=%0d want 1 0 0",
                         bus.in_ready, bus.res_valid, bus.res_expected);
    end
    n_cmp++;
    if (total_cnt !== 16'd0 || err_cnt !== 16'd0 || abs_err_sum !== 32'd0 || max_abs_err !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_stats: got %0d %0d %0d %0d want all 0", total_cnt, err_cnt, abs_err_sum, max_abs_err);
    end
    pulses = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.res_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: got %0d pulses want 0", pulses); end
    send(8'd1, 8'd2, 16'd2, -1, lat, rok);
    model_txn(1, 2, 2);
    n_cmp++;
    if (lat !== WIDTH + 1 || bus.res_match !== 1'b1 || bus.res_expected !== 16'd2 || total_cnt !== 16'(m_total)) begin
      n_fail++; $display("FAIL rst_mid_after: got lat=%0d match=%b exp=%0d total=%0d want %0d 1 2 %0d",
                         lat, bus.res_match, bus.res_expected, total_cnt, WIDTH + 1, m_total);
    end
  endtask

  task automatic test_saturation();
    int acc_n, pulses;
    longint st, se, ss, sm;
    bit will_acc;
    acc_n = 0; pulses = 0; st = 0; se = 0; ss = 0; sm = 0;
    @(negedge clk);
    bus_s.in_valid = 1'b1; bus_s.a = 8'd1; bus_s.b = 8'd1; bus_s.p_dut = 16'd0;
    for (int cyc = 0; cyc < 17 * (WIDTH + 2) + 40; cyc++) begin
      will_acc = (bus_s.in_valid === 1'b1) && (bus_s.in_ready === 1'b1);
      if (will_acc) begin
        if (st < 15) st = st + 1;
        if (se < 15) se = se + 1;
        ss = ss + 1;
        if (sm < 1) sm = 1;
      end
      @(posedge clk);
      @(negedge clk);
      if (bus_s.res_valid === 1'b1) pulses++;
      if (will_acc) begin
        acc_n++;
        if (acc_n == 17) bus_s.in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (pulses !== 17) begin n_fail++; $display("FAIL sat_pulses: got %0d want 17", pulses); end
    n_cmp++;
    if (s_total !== 4'(st) || s_err !== 4'(se)) begin
      n_fail++; $display("FAIL sat_counts: got total=%0d err=%0d want %0d %0d", s_total, s_err, st, se);
    end
    n_cmp++;
    if (s_sum !== 32'(ss) || s_max !== 16'(sm)) begin
      n_fail++; $display("FAIL sat_err_sum: got sum=%0d max=%0d want %0d %0d", s_sum, s_max, ss, sm);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.a = 8'd0; bus.b = 8'd0; bus.p_dut = 16'd0;
    bus_s.in_valid = 1'b0; bus_s.a = 8'd0; bus_s.b = 8'd0; bus_s.p_dut = 16'd0;
    test_reset();
    test_basic();
    test_mismatch();
    test_random();
    test_back_to_back();
    test_clear_cmp();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
